// File: rtl/pe_act_receiver_pkg.sv
// Shared PE definitions: bus widths and the receive-side FSM encoding.
package pe_act_receiver_pkg;

    localparam int PeDataBus  = 16;
    localparam int PeAddrBus  = 10;
    localparam int PEQueueBus = PeAddrBus + PeDataBus;

    typedef enum logic [1:0] {
        RX_RECV       = 2'd0,
        RX_WAIT_DRAIN = 2'd1,
        RX_DONE       = 2'd2
    } rx_state_t;

endpackage

// File: rtl/pe_skid_buffer.sv
// Two-entry FIFO between the router side and the activation queue.
module pe_skid_buffer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            // simultaneous write and pop leaves the occupancy unchanged
            case ({wr_en, rd_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pe_act_receiver.sv
// Receives broadcast activation flits, drops zeros, feeds the activation queue
// and signals layer completion once every PE's end marker has arrived.
//
// state         | meaning
// RX_RECV       | accepting flits, collecting end-of-broadcast markers
// RX_WAIT_DRAIN | all markers seen; router held off until buffer and queue empty
// RX_DONE       | one-cycle comp_done, marker mask cleared
module pe_act_receiver
    import pe_act_receiver_pkg::*;
#(
    parameter int NUM_PE = 64,
    parameter int DATA_W = PeDataBus,
    parameter int IDX_W  = PeAddrBus,
    parameter int SRC_W  = $clog2(NUM_PE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    recv_valid,
    output logic                    recv_rdy,
    input  logic                    recv_last,
    input  logic [SRC_W-1:0]        recv_src,
    input  logic [IDX_W-1:0]        recv_idx,
    input  logic [DATA_W-1:0]       recv_data,
    input  logic                    queue_full,
    input  logic                    queue_empty,
    output logic                    push_act,
    output logic [IDX_W+DATA_W-1:0] act_in,
    output logic                    comp_done,
    output logic                    err_dup
);

    rx_state_t                state;
    logic [NUM_PE-1:0]        seen;
    logic [NUM_PE-1:0]        seen_set;
    logic [1:0]               skid_cnt;
    logic [IDX_W+DATA_W-1:0]  skid_head;
    logic                     xfer;
    logic                     mark;
    logic                     wr_en;

    assign recv_rdy = !rst && (state == RX_RECV) && (skid_cnt < 2'd2);
    assign xfer     = recv_valid && recv_rdy;
    assign mark     = xfer && recv_last;
    assign wr_en    = xfer && !recv_last && (recv_data != '0);

    assign push_act  = (skid_cnt != 2'd0) && !queue_full;
    assign act_in    = skid_head;
    assign comp_done = (state == RX_DONE);

    always_comb begin
        seen_set = '0;
        if (mark) begin
            seen_set[recv_src] = 1'b1;
        end
    end

    pe_skid_buffer #(
        .W(IDX_W + DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({recv_idx, recv_data}),
        .rd_en   (push_act),
        .count   (skid_cnt),
        .head    (skid_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_RECV;
            seen    <= '0;
            err_dup <= 1'b0;
        end else begin
            case (state)
                RX_RECV: begin
                    seen <= seen | seen_set;
                    // the final marker moves us on in the same cycle it lands
                    if (&(seen | seen_set)) begin
                        state <= RX_WAIT_DRAIN;
                    end
                end
                RX_WAIT_DRAIN: begin
                    if ((skid_cnt == 2'd0) && queue_empty) begin
                        state <= RX_DONE;
                    end
                end
                RX_DONE: begin
                    seen  <= '0;
                    state <= RX_RECV;
                end
                default: state <= RX_RECV;
            endcase
            if (mark && seen[recv_src]) begin
                err_dup <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_act_receiver.sv
// Directed and randomized checks for pe_act_receiver with a 4-PE configuration.
module tb_pe_act_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        recv_valid;
    logic        recv_rdy;
    logic        recv_last;
    logic [1:0]  recv_src;
    logic [9:0]  recv_idx;
    logic [15:0] recv_data;
    logic        queue_full;
    logic        queue_empty;
    logic        push_act;
    logic [25:0] act_in;
    logic        comp_done;
    logic        err_dup;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_act_receiver #(
        .NUM_PE(4),
        .DATA_W(16),
        .IDX_W (10),
        .SRC_W (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .recv_valid (recv_valid),
        .recv_rdy   (recv_rdy),
        .recv_last  (recv_last),
        .recv_src   (recv_src),
        .recv_idx   (recv_idx),
        .recv_data  (recv_data),
        .queue_full (queue_full),
        .queue_empty(queue_empty),
        .push_act   (push_act),
        .act_in     (act_in),
        .comp_done  (comp_done),
        .err_dup    (err_dup)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic v, input logic last, input logic [1:0] src,
                         input logic [9:0] idx, input logic [15:0] data,
                         input logic qf, input logic qe);
        @(negedge clk);
        recv_valid  = v;
        recv_last   = last;
        recv_src    = src;
        recv_idx    = idx;
        recv_data   = data;
        queue_full  = qf;
        queue_empty = qe;
        #1;
    endtask

    logic [25:0] mq[$];
    logic        exp_rdy;
    logic        exp_push;
    logic        v;
    logic        qf;
    logic [9:0]  ridx;
    logic [15:0] rdata;

    initial begin
        rst = 1'b1; recv_valid = 1'b0; recv_last = 1'b0; recv_src = '0;
        recv_idx = '0; recv_data = '0; queue_full = 1'b0; queue_empty = 1'b1;

        // reset values
        @(negedge clk); #1;
        chk("rst_rdy", 32'(recv_rdy), 0);
        chk("rst_push", 32'(push_act), 0);
        chk("rst_act", 32'(act_in), 0);
        chk("rst_done", 32'(comp_done), 0);
        chk("rst_err", 32'(err_dup), 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_rdy", 32'(recv_rdy), 1);

        // zero drop and one-cycle latency
        drive(1, 0, 0, 10'd3, 16'h0012, 0, 1);
        chk("t1_push_n", 32'(push_act), 0);
        drive(1, 0, 0, 10'd4, 16'h0000, 0, 1);
        chk("t1_push_n1", 32'(push_act), 1);
        chk("t1_act_n1", 32'(act_in), {10'd3, 16'h0012});
        drive(1, 0, 0, 10'd5, 16'h0100, 0, 1);
        chk("t1_push_n2", 32'(push_act), 0);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t1_push_n3", 32'(push_act), 1);
        chk("t1_act_n3", 32'(act_in), {10'd5, 16'h0100});
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t1_push_n4", 32'(push_act), 0);

        // back-pressure
        drive(1, 0, 0, 10'd20, 16'h0a01, 1, 1);
        chk("t2_rdy0", 32'(recv_rdy), 1);
        drive(1, 0, 0, 10'd21, 16'h0a02, 1, 1);
        chk("t2_rdy1", 32'(recv_rdy), 1);
        drive(1, 0, 0, 10'd22, 16'h0a03, 1, 1);
        chk("t2_rdy2", 32'(recv_rdy), 0);
        drive(1, 0, 0, 10'd22, 16'h0a03, 1, 1);
        chk("t2_rdy3", 32'(recv_rdy), 0);
        chk("t2_push_full", 32'(push_act), 0);
        drive(1, 0, 0, 10'd22, 16'h0a03, 0, 1);
        chk("t2_rdy_rel", 32'(recv_rdy), 0);
        chk("t2_push_a", 32'(push_act), 1);
        chk("t2_act_a", 32'(act_in), {10'd20, 16'h0a01});
        drive(1, 0, 0, 10'd22, 16'h0a03, 0, 1);
        chk("t2_rdy_back", 32'(recv_rdy), 1);
        chk("t2_act_b", 32'(act_in), {10'd21, 16'h0a02});
        drive(1, 0, 0, 10'd23, 16'h0a04, 0, 1);
        chk("t2_push_c", 32'(push_act), 1);
        chk("t2_act_c", 32'(act_in), {10'd22, 16'h0a03});
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t2_act_d", 32'(act_in), {10'd23, 16'h0a04});
        chk("t2_push_d", 32'(push_act), 1);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t2_push_end", 32'(push_act), 0);

        // markers 2,0,3,1 with the queue empty
        drive(1, 1, 2, 10'd0, 16'h0000, 0, 1);
        chk("t3_rdy_m2", 32'(recv_rdy), 1);
        drive(1, 1, 0, 10'd0, 16'h0000, 0, 1);
        chk("t3_rdy_m0", 32'(recv_rdy), 1);
        drive(1, 1, 3, 10'd0, 16'h0000, 0, 1);
        chk("t3_rdy_m3", 32'(recv_rdy), 1);
        chk("t3_done_early", 32'(comp_done), 0);
        drive(1, 1, 1, 10'd0, 16'h0000, 0, 1);
        chk("t3_rdy_m1", 32'(recv_rdy), 1);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t3_rdy_wait", 32'(recv_rdy), 0);
        chk("t3_done_n1", 32'(comp_done), 0);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t3_done_n2", 32'(comp_done), 1);
        chk("t3_rdy_done", 32'(recv_rdy), 0);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t3_done_n3", 32'(comp_done), 0);
        chk("t3_rdy_n3", 32'(recv_rdy), 1);

        // completion waits for the downstream queue
        for (int s = 0; s < 4; s++) begin
            drive(1, 1, 2'(s), 10'd0, 16'h0000, 0, 0);
            chk("t4_rdy_mark", 32'(recv_rdy), 1);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 10'd9, 16'h0077, 0, 0);
            chk("t4_rdy_hold", 32'(recv_rdy), 0);
            chk("t4_done_hold", 32'(comp_done), 0);
        end
        drive(1, 0, 0, 10'd9, 16'h0077, 0, 1);
        chk("t4_done_m", 32'(comp_done), 0);
        chk("t4_rdy_m", 32'(recv_rdy), 0);
        drive(1, 0, 0, 10'd9, 16'h0077, 0, 1);
        chk("t4_done_m1", 32'(comp_done), 1);
        chk("t4_rdy_m1", 32'(recv_rdy), 0);
        drive(1, 0, 0, 10'd9, 16'h0077, 0, 1);
        chk("t4_done_m2", 32'(comp_done), 0);
        chk("t4_rdy_m2", 32'(recv_rdy), 1);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t4_push", 32'(push_act), 1);
        chk("t4_act", 32'(act_in), {10'd9, 16'h0077});

        // duplicate marker
        drive(1, 1, 2, 10'd0, 16'h0000, 0, 1);
        chk("t5_err_a", 32'(err_dup), 0);
        drive(1, 1, 2, 10'd0, 16'h0000, 0, 1);
        chk("t5_err_b", 32'(err_dup), 0);
        drive(1, 1, 0, 10'd0, 16'h0000, 0, 1);
        chk("t5_err_set", 32'(err_dup), 1);
        drive(1, 1, 3, 10'd0, 16'h0000, 0, 1);
        drive(1, 1, 1, 10'd0, 16'h0000, 0, 1);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t5_done", 32'(comp_done), 1);
        chk("t5_err_done", 32'(err_dup), 1);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t5_err_after", 32'(err_dup), 1);

        // reset mid-layer with buffered data
        drive(1, 1, 0, 10'd0, 16'h0000, 0, 1);
        drive(1, 1, 1, 10'd0, 16'h0000, 0, 1);
        drive(1, 1, 3, 10'd0, 16'h0000, 0, 1);
        drive(1, 0, 0, 10'd30, 16'h1111, 1, 1);
        drive(1, 0, 0, 10'd31, 16'h2222, 1, 1);
        drive(0, 0, 0, 10'd0, 16'h0000, 1, 1);
        chk("t6_rdy_full", 32'(recv_rdy), 0);
        @(negedge clk); rst = 1'b1; queue_full = 1'b0; #1;
        chk("t6_rdy_in_rst", 32'(recv_rdy), 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("t6_push", 32'(push_act), 0);
        chk("t6_act", 32'(act_in), 0);
        chk("t6_done", 32'(comp_done), 0);
        chk("t6_err", 32'(err_dup), 0);
        chk("t6_rdy", 32'(recv_rdy), 1);
        drive(1, 1, 2, 10'd0, 16'h0000, 0, 1);
        chk("t6_rdy_m2", 32'(recv_rdy), 1);
        drive(1, 1, 0, 10'd0, 16'h0000, 0, 1);
        chk("t6_rdy_m0", 32'(recv_rdy), 1);
        drive(1, 1, 1, 10'd0, 16'h0000, 0, 1);
        chk("t6_rdy_m1", 32'(recv_rdy), 1);
        drive(1, 1, 3, 10'd0, 16'h0000, 0, 1);
        chk("t6_rdy_m3", 32'(recv_rdy), 1);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t6_done_n1", 32'(comp_done), 0);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t6_done_n2", 32'(comp_done), 1);
        chk("t6_err_fresh", 32'(err_dup), 0);
        drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
        chk("t6_rdy_n3", 32'(recv_rdy), 1);

        // random activation traffic against an in-order buffer model
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            v     = ($urandom_range(0, 3) != 0);
            qf    = ($urandom_range(0, 9) < 3);
            ridx  = 10'($urandom);
            rdata = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            drive(v, 0, 0, ridx, rdata, qf, 1);
            exp_rdy  = (mq.size() < 2);
            exp_push = (mq.size() != 0) && !qf;
            chk("rnd_rdy", 32'(recv_rdy), 32'(exp_rdy));
            chk("rnd_push", 32'(push_act), 32'(exp_push));
            if (exp_push) chk("rnd_act", 32'(act_in), 32'(mq[0]));
            if (exp_push) void'(mq.pop_front());
            if (v && exp_rdy && rdata != 16'h0000) mq.push_back({ridx, rdata});
        end
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 10'd0, 16'h0000, 0, 1);
            exp_push = (mq.size() != 0);
            chk("drain_push", 32'(push_act), 32'(exp_push));
            if (exp_push) chk("drain_act", 32'(act_in), 32'(mq[0]));
            if (exp_push) void'(mq.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
